// File: rtl/hist_pkg.sv
// hist_pkg: shared types and constants for the histogram accumulator.
//   hist_state_e : FSM states ACCUM / READOUT / CLEAR
//   bin_w()      : bin index width for a given bin count
//   DEF_*        : default parameter values
package hist_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        READOUT = 2'd1,
        CLEAR   = 2'd2
    } hist_state_e;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_NUM_BINS = 16;
    localparam int unsigned DEF_CNT_W    = 8;

    function automatic int unsigned bin_w(input int unsigned num_bins);
        return $clog2(num_bins);
    endfunction

endpackage

// File: rtl/hist_bin_bank.sv
// hist_bin_bank: per-bin counter array.
//   clk, rst        : clock, asynchronous active-high reset
//   inc_en_i/idx_i  : increment port
//   clr_en_i/idx_i  : clear port (clear wins over increment on the same bin)
//   rd_en_i/idx_i   : read request; rd_count_o is registered
//   sat_hit_o       : increment attempted on a full counter (saturating build only)
// Macro HIST_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module hist_bin_bank
    import hist_pkg::*;
#(
    parameter int unsigned NUM_BINS = DEF_NUM_BINS,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inc_en_i,
    input  logic [bin_w(NUM_BINS)-1:0]    inc_idx_i,
    input  logic                          clr_en_i,
    input  logic [bin_w(NUM_BINS)-1:0]    clr_idx_i,
    input  logic                          rd_en_i,
    input  logic [bin_w(NUM_BINS)-1:0]    rd_idx_i,
    output logic [CNT_W-1:0]              rd_count_o,
    output logic                          sat_hit_o
);

    localparam int unsigned BIN_W = bin_w(NUM_BINS);

    logic [CNT_W-1:0] cnt_q [NUM_BINS];
    logic [CNT_W-1:0] cnt_d [NUM_BINS];
    logic [CNT_W-1:0] rd_q;
    logic             inc_go;

`ifdef HIST_SATURATE_EN
    logic full;
    assign full      = (cnt_q[inc_idx_i] == '1);
    assign inc_go    = inc_en_i && !full;
    assign sat_hit_o = inc_en_i && full;
`else
    assign inc_go    = inc_en_i;
    assign sat_hit_o = 1'b0;
`endif

    always_comb begin
        for (int unsigned i = 0; i < NUM_BINS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_en_i && clr_idx_i == BIN_W'(i))
                cnt_d[i] = '0;
            else if (inc_go && inc_idx_i == BIN_W'(i))
                cnt_d[i] = cnt_q[i] + 1'b1;
        end
    end

    // The read samples next-state values so a sample accepted in the same
    // cycle as the read request is already reflected in the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_BINS; i++)
                cnt_q[i] <= '0;
            rd_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_BINS; i++)
                cnt_q[i] <= cnt_d[i];
            if (rd_en_i)
                rd_q <= cnt_d[rd_idx_i];
        end
    end

    assign rd_count_o = rd_q;

endmodule

// File: rtl/hist_core.sv
// hist_core: histogram accumulator with streamed readout and clear sweep.
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_data/in_ready: sample stream, bin = top bin_w(NUM_BINS) bits
//   start_rd, clear          : single-cycle requests (clear wins)
//   rd_valid/rd_ready        : readout stream with rd_bin, rd_count, rd_last
//   busy                     : READOUT or CLEAR in progress
//   ovf                      : sticky saturation flag
// Macro HIST_SATURATE_EN: saturating counters and live ovf; else wrap, ovf=0.
module hist_core
    import hist_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_BINS = DEF_NUM_BINS,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       start_rd,
    input  logic                       clear,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [bin_w(NUM_BINS)-1:0] rd_bin,
    output logic [CNT_W-1:0]           rd_count,
    output logic                       rd_last,
    output logic                       busy,
    output logic                       ovf
);

    localparam int unsigned     BIN_W    = bin_w(NUM_BINS);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    hist_state_e      state_q;
    logic             rd_valid_q, rd_last_q, busy_q, in_ready_q, ovf_q;
    logic [BIN_W-1:0] rd_bin_q, clr_idx_q;

    logic             inc_en, rd_en, hs, sat_hit;
    logic [BIN_W-1:0] rd_idx;

    if (BIN_W < DATA_W) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^in_data[DATA_W-BIN_W-1:0];
    end

    assign inc_en = in_valid && in_ready_q;
    assign hs     = rd_valid_q && rd_ready;

    // Prefetch: bin 0 on entry to READOUT, the following bin on each handshake.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = '0;
        if (state_q == ACCUM && start_rd && !clear) begin
            rd_en  = 1'b1;
            rd_idx = '0;
        end else if (state_q == READOUT && hs && !rd_last_q) begin
            rd_en  = 1'b1;
            rd_idx = rd_bin_q + 1'b1;
        end
    end

    hist_bin_bank #(
        .NUM_BINS (NUM_BINS),
        .CNT_W    (CNT_W)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .inc_en_i   (inc_en),
        .inc_idx_i  (in_data[DATA_W-1 -: BIN_W]),
        .clr_en_i   (state_q == CLEAR),
        .clr_idx_i  (clr_idx_q),
        .rd_en_i    (rd_en),
        .rd_idx_i   (rd_idx),
        .rd_count_o (rd_count),
        .sat_hit_o  (sat_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            rd_valid_q <= 1'b0;
            rd_bin_q   <= '0;
            rd_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            clr_idx_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (sat_hit)
                        ovf_q <= 1'b1;
                    if (clear) begin
                        state_q    <= CLEAR;
                        clr_idx_q  <= '0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                    end else if (start_rd) begin
                        state_q    <= READOUT;
                        rd_valid_q <= 1'b1;
                        rd_bin_q   <= '0;
                        rd_last_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b0;
                    end
                end
                READOUT: begin
                    if (hs) begin
                        if (rd_last_q) begin
                            state_q    <= ACCUM;
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                            busy_q     <= 1'b0;
                            in_ready_q <= 1'b1;
                        end else begin
                            rd_bin_q  <= rd_bin_q + 1'b1;
                            rd_last_q <= (rd_bin_q + 1'b1 == LAST_BIN);
                        end
                    end
                end
                CLEAR: begin
                    ovf_q     <= 1'b0;
                    clr_idx_q <= clr_idx_q + 1'b1;
                    if (clr_idx_q == LAST_BIN) begin
                        state_q    <= ACCUM;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign rd_valid = rd_valid_q;
    assign rd_bin   = rd_bin_q;
    assign rd_last  = rd_last_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_hist_core.sv
// tb_hist_core: directed, scoreboard-based bench for hist_core.
//   u_dut : default parameters (8-bit counters, 16 bins)
//   u_dut4: CNT_W=4 instance for the overflow scenario
module tb_hist_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0, start_rd = 1'b0, clear = 1'b0, rd_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, rd_valid, rd_last, busy, ovf;
    logic [3:0] rd_bin;
    logic [7:0] rd_count;

    logic       in_valid4 = 1'b0, start_rd4 = 1'b0, clear4 = 1'b0, rd_ready4 = 1'b1;
    logic [7:0] in_data4 = '0;
    logic       in_ready4, rd_valid4, rd_last4, busy4, ovf4;
    logic [3:0] rd_bin4;
    logic [3:0] rd_count4;

    int unsigned errors = 0;
    int unsigned checks = 0;

    typedef struct {
        int unsigned bin;
        int unsigned cnt;
        bit          last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned model[16];

    always #5 clk = ~clk;

    hist_core #(.DATA_W(8), .NUM_BINS(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .start_rd(start_rd), .clear(clear),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bin(rd_bin),
        .rd_count(rd_count), .rd_last(rd_last), .busy(busy), .ovf(ovf)
    );

    hist_core #(.DATA_W(8), .NUM_BINS(16), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4),
        .in_ready(in_ready4), .start_rd(start_rd4), .clear(clear4),
        .rd_valid(rd_valid4), .rd_ready(rd_ready4), .rd_bin(rd_bin4),
        .rd_count(rd_count4), .rd_last(rd_last4), .busy(busy4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_add(input logic [7:0] d);
        model[d[7:4]] = (model[d[7:4]] + 1) % 256;
    endtask

    task automatic model_zero();
        for (int i = 0; i < 16; i++) model[i] = 0;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        model_add(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_rd_valid"}, rd_valid, 0);
        check({pfx, "_rd_bin"},   rd_bin,   0);
        check({pfx, "_rd_count"}, rd_count, 0);
        check({pfx, "_rd_last"},  rd_last,  0);
        check({pfx, "_busy"},     busy,     0);
        check({pfx, "_ovf"},      ovf,      0);
        check({pfx, "_in_ready"}, in_ready, 1);
    endtask

    // Full readout of u_dut; optionally a sample is offered alongside start_rd.
    task automatic do_readout(input bit bp, input bit with_smp, input logic [7:0] smp);
        int unsigned cyc;
        bit          stalled;
        beat_t       e;
        logic [3:0]  sb;
        logic [7:0]  sc;
        logic        sl;
        start_rd = 1'b1;
        if (with_smp) begin
            in_valid = 1'b1;
            in_data  = smp;
            model_add(smp);
        end
        for (int i = 0; i < 16; i++) begin
            e.bin  = i;
            e.cnt  = model[i];
            e.last = (i == 15);
            exp_q.push_back(e);
        end
        tick();
        start_rd = 1'b0;
        in_valid = 1'b0;
        check("rd_first_valid", rd_valid, 1);
        check("rd_in_ready_low", in_ready, 0);
        check("rd_busy_high", busy, 1);
        stalled = 1'b0;
        sb = '0; sc = '0; sl = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            check("rd_valid_hold", rd_valid, 1);
            if (stalled) begin
                check("stall_bin", rd_bin, sb);
                check("stall_count", rd_count, sc);
                check("stall_last", rd_last, sl);
            end
            rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_ready) begin
                e = exp_q.pop_front();
                check($sformatf("beat%0d_bin", e.bin), rd_bin, e.bin);
                check($sformatf("beat%0d_count", e.bin), rd_count, e.cnt);
                check($sformatf("beat%0d_last", e.bin), rd_last, e.last);
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                sb = rd_bin; sc = rd_count; sl = rd_last;
            end
            tick();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            check("rd_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        if (!bp) check("rd_cycles", cyc, 16);
        rd_ready = 1'b0;
        check("rd_done_valid", rd_valid, 0);
        check("rd_done_in_ready", in_ready, 1);
        check("rd_done_busy", busy, 0);
    endtask

    int unsigned exp4;
    bit          sat_build;
    int unsigned wait_cyc;

    initial begin
`ifdef HIST_SATURATE_EN
        sat_build = 1'b1;
`else
        sat_build = 1'b0;
`endif
        model_zero();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        tick();
        check_reset_outputs("rst_rel");

        // Accumulate and read out
        send(8'h05);
        send(8'h13);
        send(8'h1F);
        send(8'hF0);
        check("model_bin1", model[1], 2);
        do_readout(1'b0, 1'b0, 8'h00);

        // Backpressured readout of the same, unchanged counts
        do_readout(1'b1, 1'b0, 8'h00);

        // Sample accepted together with start_rd
        do_readout(1'b0, 1'b1, 8'h20);

        // clear and start_rd together: clear wins, no beats
        clear    = 1'b1;
        start_rd = 1'b1;
        tick();
        clear    = 1'b0;
        start_rd = 1'b0;
        model_zero();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("clr%0d_busy", i), busy, 1);
            check($sformatf("clr%0d_no_beat", i), rd_valid, 0);
            check($sformatf("clr%0d_in_ready", i), in_ready, 0);
            tick();
        end
        check("clr_done_busy", busy, 0);
        check("clr_done_in_ready", in_ready, 1);
        do_readout(1'b0, 1'b0, 8'h00);
        check("ovf_main", ovf, 0);

        // Overflow on the 4-bit instance
        in_valid4 = 1'b1;
        in_data4  = 8'h00;
        repeat (17) tick();
        in_valid4 = 1'b0;
        exp4 = sat_build ? 15 : (17 % 16);
        check("ovf4_flag", ovf4, sat_build ? 1 : 0);
        start_rd4 = 1'b1;
        tick();
        start_rd4 = 1'b0;
        check("ovf4_valid", rd_valid4, 1);
        check("ovf4_bin", rd_bin4, 0);
        check("ovf4_count", rd_count4, exp4);
        repeat (16) tick();
        check("ovf4_done", rd_valid4, 0);
        check("ovf4_hold", ovf4, sat_build ? 1 : 0);
        clear4 = 1'b1;
        tick();
        clear4 = 1'b0;
        tick();
        check("ovf4_cleared", ovf4, 0);
        repeat (16) tick();
        check("ovf4_clr_done", busy4, 0);

        // Reset in the middle of a readout
        send(8'h77);
        send(8'h33);
        send(8'h71);
        start_rd = 1'b1;
        rd_ready = 1'b1;
        tick();
        start_rd = 1'b0;
        wait_cyc = 0;
        while (!(rd_valid && rd_bin == 4'd7) && wait_cyc < 40) begin
            tick();
            wait_cyc++;
        end
        check("mid_reached_bin7", rd_bin, 7);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        rst = 1'b0;
        rd_ready = 1'b0;
        model_zero();
        check_reset_outputs("mid_rel");
        do_readout(1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hist_core.md
# hist_core

Parametrised histogram accumulator for the TinyTapeout histogramming design. Samples arrive on a valid/ready stream; the upper bits of each sample select a bin; the bin's counter increments. A host-triggered readout streams every bin count out on a second valid/ready port. A clear sweep zeroes all bins. The block sits between the `ui_in` sample path and the `uo_out`/`uio` output mux inside the `tt_um_*` top.

## Interface
- `DATA_W`, 8, sample width.
- `NUM_BINS`, 16, number of bins; power of two, 2..2^DATA_W.
- `CNT_W`, 8, counter width per bin.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample present.
- `in_data`  in  DATA_W  sample; bin = `in_data[DATA_W-1 -: BIN_W]`, where BIN_W = clog2(NUM_BINS).
- `in_ready`  out  1  high only in ACCUM.
- `start_rd`  in  1  single-cycle pulse; requests a readout.
- `clear`  in  1  single-cycle pulse; requests a clear sweep.
- `rd_valid`  out  1  readout beat valid.
- `rd_ready`  in  1  consumer accepts the beat.
- `rd_bin`  out  BIN_W  bin index of the current beat.
- `rd_count`  out  CNT_W  count of the current beat.
- `rd_last`  out  1  high with the beat for bin NUM_BINS-1.
- `busy`  out  1  high in READOUT or CLEAR.
- `ovf`  out  1  sticky saturation flag (see Configuration).

## Operation
- FSM has three states: ACCUM, READOUT, CLEAR. Reset state is ACCUM.
- Reset values: all counters 0, `rd_valid`=0, `rd_bin`=0, `rd_count`=0, `rd_last`=0, `busy`=0, `ovf`=0, `in_ready`=1.
- ACCUM: each `in_valid && in_ready` increments counter[bin] by 1.
- ACCUM exits:
  - `clear` → CLEAR.
  - `start_rd` → READOUT.
  - `clear` and `start_rd` in the same cycle: `clear` wins; `start_rd` is dropped.
- A sample accepted in the same cycle as `start_rd` or `clear` is counted before the state change.
- READOUT:
  - Beats cover bins 0..NUM_BINS-1 in order.
  - `rd_bin`, `rd_count` and `rd_last` hold stable while `rd_valid && !rd_ready`.
  - Each handshake advances to the next bin.
  - The handshake with `rd_last` returns the FSM to ACCUM.
  - Readout does not modify the counts.
  - `start_rd` and `clear` are ignored during READOUT.
- CLEAR:
  - Zeroes one bin per cycle, bins 0..NUM_BINS-1, then returns to ACCUM.
  - `ovf` is cleared in the first CLEAR cycle.
  - Inputs are ignored during CLEAR.
- Counter arithmetic is modulo 2^CNT_W unless `HIST_SATURATE_EN` is defined.
- Asserting `rst` in any state aborts the operation immediately and restores the reset values.

## Timing
- Increment latency is 1 cycle: a sample accepted at edge N is visible in the counter after edge N.
- A sample accepted in the cycle before `start_rd` is included in the readout.
- `start_rd` sampled at edge N gives `rd_valid`=1 with `rd_bin`=0 after edge N. `in_ready` falls at the same edge.
- With `rd_ready` held at 1, readout takes exactly NUM_BINS cycles. `in_ready` rises after the edge that completes the last handshake.
- CLEAR takes exactly NUM_BINS cycles; `busy` stays high for all of them.
- `rd_count` is registered and changes only on an edge where the FSM enters READOUT or a handshake completes.

## Configuration
- Macro: `HIST_SATURATE_EN`.
- Defined:
  - An increment of a counter already at 2^CNT_W-1 leaves the counter unchanged.
  - The same increment sets `ovf`, which stays set until CLEAR or reset.
- Undefined:
  - Counters wrap from 2^CNT_W-1 to 0.
  - `ovf` is tied to 0.

## Structure
- Package `hist_pkg` holds:
  - the state enum `hist_state_e` (ACCUM, READOUT, CLEAR);
  - a `clog2`-based BIN_W helper;
  - default parameter constants.
- Sub-module `hist_bin_bank` holds the counter array, with:
  - one increment port (index, enable);
  - one clear port (index, enable);
  - one registered read port.
  `hist_core` keeps the FSM, the handshakes and `ovf`.

## Test plan
- Accumulate, then read out: defaults; send samples 0x05, 0x13, 0x1F, 0xF0; `start_rd`. Required: bins 0, 1, 15 read 1, 2, 1; all other bins read 0; `rd_last` only with `rd_bin`=15.
- Backpressure: toggle `rd_ready` randomly during readout. Required: each bin appears exactly once, in order; beat values stay stable while stalled.
- Same-cycle events:
  - `in_valid` (data 0x20) together with `start_rd`: bin 2 reads 1.
  - `clear` together with `start_rd`: CLEAR runs for 16 cycles with no beats; a following readout gives all zeros.
- Overflow, CNT_W=4: send 17 samples of 0x00.
  - With `HIST_SATURATE_EN`: bin 0 reads 15 and `ovf`=1.
  - Without it: bin 0 reads 1 and `ovf`=0.
- Reset mid-readout: assert `rst` at bin 7. Required: outputs at reset values, `in_ready`=1, and the next readout gives all zeros.
